// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Function : bit-serial unsigned subtractor, LSB first, one bit per clock
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // One extra counter bit so the count never wraps before the last bit.
  localparam int                c_cnt_w   = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(WIDTH - 1);
  localparam logic [1:0]         c_st_idle = 2'd0;
  localparam logic [1:0]         c_st_run  = 2'd1;
  localparam logic [1:0]         c_st_done = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   res_q,    res_d;
  logic               bin_q,    bin_d;
  logic [c_cnt_w-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   diff_q,   diff_d;
  logic               borrow_q, borrow_d;

  logic             w_d1, w_br1, w_dbit, w_br2, w_bout;
  logic [WIDTH-1:0] w_res_next;

  // Two cascaded half-subtractors on the current LSB pair.
  assign w_d1       = a_sh_q[0] ^ b_sh_q[0];
  assign w_br1      = ~a_sh_q[0] & b_sh_q[0];
  assign w_dbit     = w_d1 ^ bin_q;
  assign w_br2      = ~w_d1 & bin_q;
  assign w_bout     = w_br1 | w_br2;
  assign w_res_next = {w_dbit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = c_st_run;
        end
      end
      c_st_run: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = w_res_next;
        bin_d  = w_bout;
        cnt_d  = cnt_q + c_cnt_w'(1);
        if (cnt_q == c_last) begin
          diff_d   = w_res_next;
          borrow_d = w_bout;
          state_d  = c_st_done;
        end
      end
      c_st_done: state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= c_st_idle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy       = (state_q == c_st_run) || (state_q == c_st_done);
  assign done       = (state_q == c_st_done);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Function : directed and random self-checking bench for serial_subtractor
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, borrow8;
  logic [7:0]  diff8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, borrow16;
  logic [15:0] diff16;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16)
  );

  // Issues one WIDTH=8 operation; returns at the done cycle (or after a bound).
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output logic held);
    logic [7:0] d0;
    d0 = diff8; held = 1'b1; lat = -1;
    start8 = 1'b1; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
      if (diff8 !== d0) held = 1'b0;
    end
  endtask

  task automatic run_op16(input logic [15:0] av, input logic [15:0] bv, output int lat);
    lat = -1;
    start16 = 1'b1; a16 = av; b16 = bv;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done16) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy8); end
    compared++; if (done8 !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done8); end
    compared++; if (diff8 !== 8'd0) begin mismatched++; $display("FAIL reset_diff got %0d want 0", diff8); end
    compared++; if (borrow8 !== 1'b0) begin mismatched++; $display("FAIL reset_borrow got %b want 0", borrow8); end
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
    @(posedge clk); #1;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL reset_priority_busy got %b want 0", busy8); end
    start8 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic held;
    run_op8(8'd200, 8'd55, lat, held);
    compared++; if (lat != 8) begin mismatched++; $display("FAIL basic_latency got %0d want 8", lat); end
    compared++; if (diff8 !== 8'd145) begin mismatched++; $display("FAIL basic_diff got %0d want 145", diff8); end
    compared++; if (borrow8 !== 1'b0) begin mismatched++; $display("FAIL basic_borrow got %b want 0", borrow8); end
    compared++; if (busy8 !== 1'b1) begin mismatched++; $display("FAIL basic_busy_done got %b want 1", busy8); end
    compared++; if (held !== 1'b1) begin mismatched++; $display("FAIL basic_diff_held_run got %b want 1", held); end
    @(posedge clk); #1;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL basic_busy_after got %b want 0", busy8); end
    compared++; if (done8 !== 1'b0) begin mismatched++; $display("FAIL basic_done_width got %b want 0", done8); end
    compared++; if (diff8 !== 8'd145) begin mismatched++; $display("FAIL basic_diff_hold got %0d want 145", diff8); end
  endtask

  task automatic test_boundary();
    logic [7:0] va [7] = '{8'd5,   8'd0,   8'd170, 8'd255, 8'd0, 8'd255, 8'd0};
    logic [7:0] vb [7] = '{8'd10,  8'd255, 8'd170, 8'd0,   8'd0, 8'd255, 8'd1};
    logic [7:0] vd [7] = '{8'd251, 8'd1,   8'd0,   8'd255, 8'd0, 8'd0,   8'd255};
    logic       vw [7] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0, 1'b0,   1'b1};
    int lat; logic held;
    for (int i = 0; i < 7; i++) begin
      run_op8(va[i], vb[i], lat, held);
      compared++;
      if (lat != 8 || diff8 !== vd[i] || borrow8 !== vw[i]) begin
        mismatched++;
        $display("FAIL boundary_%0d a=%0d b=%0d got lat=%0d diff=%0d borrow=%b want lat=8 diff=%0d borrow=%b",
                 i, va[i], vb[i], lat, diff8, borrow8, vd[i], vw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
    @(posedge clk); #1;
    a8 = 8'd1; b8 = 8'd2;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    compared++; if (done8 !== 1'b1) begin mismatched++; $display("FAIL ignore_done_at_8 got %b want 1", done8); end
    @(posedge clk); #1;
    start8 = 1'b0;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL ignore_busy_idle got %b want 0", busy8); end
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    compared++; if (pulses != 1) begin mismatched++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    compared++; if (diff8 !== 8'd6 || borrow8 !== 1'b0) begin
      mismatched++; $display("FAIL ignore_result got diff=%0d borrow=%b want diff=6 borrow=0", diff8, borrow8);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0; int lat; logic held;
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL midreset_busy got %b want 0", busy8); end
    compared++; if (diff8 !== 8'd0 || borrow8 !== 1'b0) begin
      mismatched++; $display("FAIL midreset_result got diff=%0d borrow=%b want diff=0 borrow=0", diff8, borrow8);
    end
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    compared++; if (pulses != 0) begin mismatched++; $display("FAIL midreset_no_done got %0d want 0", pulses); end
    run_op8(8'd100, 8'd1, lat, held);
    compared++; if (lat != 8 || diff8 !== 8'd99 || borrow8 !== 1'b0) begin
      mismatched++; $display("FAIL midreset_restart got lat=%0d diff=%0d borrow=%b want lat=8 diff=99 borrow=0", lat, diff8, borrow8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic held;
    run_op8(8'd50, 8'd20, lat, held);
    compared++; if (lat != 8 || diff8 !== 8'd30) begin
      mismatched++; $display("FAIL b2b_first got lat=%0d diff=%0d want lat=8 diff=30", lat, diff8);
    end
    @(posedge clk); #1;
    compared++; if (diff8 !== 8'd30 || done8 !== 1'b0) begin
      mismatched++; $display("FAIL b2b_idle got diff=%0d done=%b want diff=30 done=0", diff8, done8);
    end
    run_op8(8'd3, 8'd7, lat, held);
    compared++; if (held !== 1'b1) begin mismatched++; $display("FAIL b2b_hold got %b want 1", held); end
    compared++; if (lat != 8 || diff8 !== 8'd252 || borrow8 !== 1'b1) begin
      mismatched++; $display("FAIL b2b_second got lat=%0d diff=%0d borrow=%b want lat=8 diff=252 borrow=1", lat, diff8, borrow8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic held; int bad8 = 0; int bad16 = 0;
    logic [7:0]  ra8, rb8, e8;
    logic [15:0] ra16, rb16, e16;
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom);
      e8 = ra8 - rb8;
      run_op8(ra8, rb8, lat, held);
      compared++;
      if (lat != 8 || diff8 !== e8 || borrow8 !== (ra8 < rb8)) begin
        mismatched++;
        if (bad8++ < 5)
          $display("FAIL random8 a=%0d b=%0d got lat=%0d diff=%0d borrow=%b want lat=8 diff=%0d borrow=%b",
                   ra8, rb8, lat, diff8, borrow8, e8, (ra8 < rb8));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom);
      e16 = ra16 - rb16;
      run_op16(ra16, rb16, lat);
      compared++;
      if (lat != 16 || diff16 !== e16 || borrow16 !== (ra16 < rb16)) begin
        mismatched++;
        if (bad16++ < 5)
          $display("FAIL random16 a=%0d b=%0d got lat=%0d diff=%0d borrow=%b want lat=16 diff=%0d borrow=%b",
                   ra16, rb16, lat, diff16, borrow16, e16, (ra16 < rb16));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
